wdt_ctrl: RTL
=============

# wdt_ctrl

Sequencing controller for the watchdog down-counter (`wdt_cnt`). It drives the counter's enable, restart and pause inputs, validates restart-key writes, and detects counter expiry. On expiry it raises either a system-reset pulse, or an interrupt first and then the reset pulse on a second expiry. It sits between the WDT register block and `wdt_cnt`, and its outputs go to the interrupt controller and the reset generator.

## Interface
Parameters:
- `WDT_CNT_WIDTH`, 32: width of the counter value.
- `RESTART_KEY`, 8'h76: the only value that restarts the counter when written.

Ports:
- `clk` input 1: the single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `clk_en` input 1: counter tick qualifier; the same signal that feeds `wdt_cnt`.
- `wdt_en` input 1: watchdog enable. Sticky internally; only reset clears it.
- `rmod` input 1: response mode. 0 = reset on first expiry; 1 = interrupt first, reset on second expiry.
- `rpl` input 3: reset pulse length selector; pulse length is 2^(rpl+1) clk cycles.
- `crr_wr` input 1: one-cycle strobe for a restart register write.
- `crr_data` input 8: data for the restart register write.
- `eoi_rd` input 1: one-cycle strobe that clears the interrupt.
- `pause_req` input 1: debug halt request.
- `cnt` input WDT_CNT_WIDTH: current counter value from `wdt_cnt`.
- `cnt_en` output 1: counter enable.
- `restart` output 1: counter reload pulse.
- `pause` output 1: counter hold.
- `wdt_int` output 1: watchdog interrupt, level.
- `wdt_sys_rst` output 1: system reset request, active-high.
- `key_err` output 1: one-cycle pulse on a wrong-key write.

## Operation
- **Reset:** state IDLE. All outputs 0. Enable latch, pulse counter and arm flag are cleared.
- **Passthrough:** `pause` = `pause_req`, registered, one-cycle latency.
- **Valid kick:** `crr_wr & (crr_data == RESTART_KEY)`, accepted only in RUN or INT_PEND.
  - Wrong key in RUN/INT_PEND gives a `key_err` pulse and no restart.
  - Any write in IDLE or RST_PULSE is ignored; no `key_err`.
- **Arm flag:** set on the first `clk_en` cycle after entering RUN. This masks the counter's initial-load cycle.
- **Timeout:** `arm & cnt_en & clk_en & ~pause & (cnt == 0)`, evaluated combinationally from the current cycle's signals.
- **IDLE:** `cnt_en` = 0. When `wdt_en` = 1 the enable latch sets, the block goes to RUN and `cnt_en` = 1.
- **RUN:**
  - Valid kick: `restart` pulse.
  - Timeout with `rmod` = 0: go to RST_PULSE.
  - Timeout with `rmod` = 1: go to INT_PEND and set `wdt_int`.
- **INT_PEND:**
  - Valid kick: `restart` pulse, clear `wdt_int`, go to RUN.
  - `eoi_rd`: clear `wdt_int`, go to RUN; the counter keeps counting.
  - Timeout: go to RST_PULSE; `wdt_int` stays set.
- **RST_PULSE:**
  - On entry, `rpl` is sampled and the pulse counter is loaded with 2^(rpl+1) - 1.
  - `wdt_sys_rst` = 1 while the counter decrements every clk, independent of `clk_en` and `pause`.
  - When the count reaches 0: `wdt_sys_rst` drops, `wdt_int` clears, a `restart` pulse is issued, and the block returns to RUN.
- **Simultaneous events:**
  - Valid kick and timeout in the same cycle: the kick wins and the timeout is discarded.
  - Timeout and `eoi_rd` in INT_PEND: the reset wins.
  - Kick and `eoi_rd` together: handled as a kick.
- **Mid-operation changes:**
  - `wdt_en` falling in any state has no effect.
  - `rmod` or `rpl` changes take effect at the next expiry.
  - `rst_n` low in any state forces IDLE and all-zero outputs immediately, including mid-pulse.

## Timing
- `crr_wr` in cycle N gives `restart` or `key_err` high in cycle N+1, for exactly one clk. `wdt_cnt` stretches the pulse to the next `clk_en`.
- `wdt_en` rising in cycle N gives `cnt_en` high in N+1.
- A timeout in cycle N gives `wdt_int` high in N+1 (rmod = 1).
- A reset-path expiry in cycle N gives `wdt_sys_rst` high from N+1 through N+2^(rpl+1). The `restart` pulse follows in cycle N+2^(rpl+1)+1.
- `eoi_rd` in N gives `wdt_int` low in N+1.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- **Reset values:** reset, then `wdt_en` = 1 with `clk_en` = 1 and `cnt` held at 0 on the arm cycle. Expect `cnt_en` = 1 one cycle later and no timeout on the first (initial-load) cycle.
- **Direct reset path:** `rmod` = 0, `rpl` = 2, drive `cnt` = 0 after arm. Expect `wdt_sys_rst` high for exactly 8 cycles, then one `restart` pulse, state RUN.
- **Interrupt then reset:** `rmod` = 1, first expiry. Expect `wdt_int` = 1. Second expiry with no `eoi_rd`: expect `wdt_sys_rst` for 2^(rpl+1) cycles, then `wdt_int` = 0.
- **Key check:** write 8'h75, expect `key_err` pulse and no `restart`. Write 8'h76, expect `restart` in N+1. Write 8'h76 in IDLE, expect no response.
- **Simultaneous events:**
  - Valid kick in the same cycle as `cnt` = 0: expect `restart` and no `wdt_int`.
  - `eoi_rd` in the same cycle as the second expiry: expect `wdt_sys_rst` asserted.
- **Pause and reset mid-operation:**
  - `pause_req` = 1 with `cnt` = 0: no expiry.
  - `rst_n` low during RST_PULSE: `wdt_sys_rst` drops immediately and `cnt_en` = 0.

Source files
------------

// File: rtl/wdt_ctrl_if.sv
// Watchdog controller bus: register-block/counter side (master)
// versus sequencing controller (slave).
interface wdt_ctrl_if #(
   parameter int WDT_CNT_WIDTH = 32
);
   logic                     clk_en;
   logic                     wdt_en;
   logic                     rmod;
   logic [2:0]               rpl;
   logic                     crr_wr;
   logic [7:0]               crr_data;
   logic                     eoi_rd;
   logic                     pause_req;
   logic [WDT_CNT_WIDTH-1:0] cnt;
   logic                     cnt_en;
   logic                     restart;
   logic                     pause;
   logic                     wdt_int;
   logic                     wdt_sys_rst;
   logic                     key_err;

   modport master (
      output clk_en, wdt_en, rmod, rpl,
      output crr_wr, crr_data, eoi_rd,
      output pause_req, cnt,
      input  cnt_en, restart, pause,
      input  wdt_int, wdt_sys_rst, key_err
   );

   modport slave (
      input  clk_en, wdt_en, rmod, rpl,
      input  crr_wr, crr_data, eoi_rd,
      input  pause_req, cnt,
      output cnt_en, restart, pause,
      output wdt_int, wdt_sys_rst, key_err
   );
endinterface

// File: rtl/wdt_ctrl.sv
// Watchdog sequencing controller: drives wdt_cnt, checks restart
// keys, and escalates expiry to interrupt and/or reset pulse.
module wdt_ctrl #(
   parameter int         WDT_CNT_WIDTH = 32,
   parameter logic [7:0] RESTART_KEY   = 8'h76
) (
   input logic       clk,
   input logic       rst_n,
   wdt_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_INT_PEND,
      S_RST_PULSE
   } state_t;

   localparam logic [WDT_CNT_WIDTH-1:0] LP_ZERO = '0;

   state_t     r_state;
   logic       r_en;
   logic       r_arm;
   logic [7:0] r_pcnt;
   logic       r_cnt_en;
   logic       r_restart;
   logic       r_pause;
   logic       r_int;
   logic       r_sys_rst;
   logic       r_key_err;

   state_t     w_state_nxt;
   logic       w_en_nxt;
   logic       w_arm_nxt;
   logic [7:0] w_pcnt_nxt;
   logic       w_int_nxt;
   logic       w_restart_nxt;
   logic       w_key_err_nxt;
   logic       w_active;
   logic       w_key_ok;
   logic       w_kick;
   logic       w_timeout;
   logic [7:0] w_pload;

   assign w_active = (r_state == S_RUN) ||
                     (r_state == S_INT_PEND);
   assign w_key_ok = (bus.crr_data == RESTART_KEY);
   assign w_kick   = w_active & bus.crr_wr & w_key_ok;
   assign w_timeout = w_active & r_arm & r_cnt_en &
                      bus.clk_en & ~r_pause &
                      (bus.cnt == LP_ZERO);
   // 2^(rpl+1)-1 without overflowing the 3-bit selector
   assign w_pload = 8'hFF >> (3'd7 - bus.rpl);

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt   = r_state;
      w_en_nxt      = r_en | bus.wdt_en;
      w_pcnt_nxt    = r_pcnt;
      w_int_nxt     = r_int;
      w_restart_nxt = 1'b0;
      w_key_err_nxt = w_active & bus.crr_wr & ~w_key_ok;
      unique case (r_state)
         S_IDLE: begin
            if (bus.wdt_en | r_en) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_kick) begin
               w_restart_nxt = 1'b1;
            end else if (w_timeout) begin
               if (bus.rmod) begin
                  w_state_nxt = S_INT_PEND;
                  w_int_nxt   = 1'b1;
               end else begin
                  w_state_nxt = S_RST_PULSE;
                  w_pcnt_nxt  = w_pload;
               end
            end
         end
         S_INT_PEND: begin
            if (w_kick) begin
               w_restart_nxt = 1'b1;
               w_int_nxt     = 1'b0;
               w_state_nxt   = S_RUN;
            end else if (w_timeout) begin
               w_state_nxt = S_RST_PULSE;
               w_pcnt_nxt  = w_pload;
            end else if (bus.eoi_rd) begin
               w_int_nxt   = 1'b0;
               w_state_nxt = S_RUN;
            end
         end
         S_RST_PULSE: begin
            if (r_pcnt == 8'd0) begin
               w_int_nxt     = 1'b0;
               w_restart_nxt = 1'b1;
               w_state_nxt   = S_RUN;
            end else begin
               w_pcnt_nxt = r_pcnt - 8'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // arm masks the counter's reload cycle after each RUN entry
      w_arm_nxt = r_arm;
      if (w_state_nxt == S_RUN && r_state != S_RUN) begin
         w_arm_nxt = 1'b0;
      end else if (r_state == S_RUN && bus.clk_en) begin
         w_arm_nxt = 1'b1;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_en      <= 1'b0;
         r_arm     <= 1'b0;
         r_pcnt    <= 8'd0;
         r_cnt_en  <= 1'b0;
         r_restart <= 1'b0;
         r_pause   <= 1'b0;
         r_int     <= 1'b0;
         r_sys_rst <= 1'b0;
         r_key_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_en      <= w_en_nxt;
         r_arm     <= w_arm_nxt;
         r_pcnt    <= w_pcnt_nxt;
         r_cnt_en  <= (w_state_nxt != S_IDLE);
         r_restart <= w_restart_nxt;
         r_pause   <= bus.pause_req;
         r_int     <= w_int_nxt;
         r_sys_rst <= (w_state_nxt == S_RST_PULSE);
         r_key_err <= w_key_err_nxt;
      end
   end

   assign bus.cnt_en      = r_cnt_en;
   assign bus.restart     = r_restart;
   assign bus.pause       = r_pause;
   assign bus.wdt_int     = r_int;
   assign bus.wdt_sys_rst = r_sys_rst;
   assign bus.key_err     = r_key_err;

endmodule
